// File: rtl/dio_di_capture.sv
// Digital-input capture: per-channel synchroniser and glitch filter, edge
// detection, sticky flags with interrupt, and channel-0 timestamp/counter.
module dio_di_capture #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned FILT_LEN  = 20,
    parameter int unsigned TS_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    input  logic [NUM_CH-1:0]     i_di,
    input  logic                  i_enable,
    input  logic                  i_clear,
    input  logic [2*NUM_CH-1:0]   i_edge_sel,
    input  logic [NUM_CH-1:0]     i_flag_clr,
    input  logic [NUM_CH-1:0]     i_irq_mask,
    output logic [NUM_CH-1:0]     o_di_level,
    output logic [NUM_CH-1:0]     o_evt_pulse,
    output logic [NUM_CH-1:0]     o_evt_flag,
    output logic [TS_WIDTH-1:0]   o_ts_free,
    output logic [TS_WIDTH-1:0]   o_ts_last,
    output logic [CNT_WIDTH-1:0]  o_evt_cnt,
    output logic                  o_irq
);

    localparam int unsigned FC_W = 16;
    localparam logic [FC_W-1:0] FILT_MAX = FC_W'(FILT_LEN - 1);

    logic [NUM_CH-1:0]            meta_q, sync_q;
    logic [NUM_CH-1:0][FC_W-1:0]  filt_cnt_q, filt_cnt_d;
    logic [NUM_CH-1:0]            level_q, level_d, level_prev_q;
    logic [NUM_CH-1:0]            evt_c;
    logic [NUM_CH-1:0]            pulse_q;
    logic [NUM_CH-1:0]            flag_q, flag_d;
    logic [TS_WIDTH-1:0]          ts_q, ts_d;
    logic [TS_WIDTH-1:0]          ts_last_q, ts_last_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic                         irq_q;

    // Glitch filter: level follows sync only after FILT_LEN consecutive mismatching cycles
    always_comb begin
        filt_cnt_d = '0;
        level_d    = level_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync_q[i] != level_q[i]) begin
                if (filt_cnt_q[i] == FILT_MAX) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    filt_cnt_d[i] = filt_cnt_q[i] + FC_W'(1);
                end
            end
        end
    end

    // Qualifying edges: selected transition type of the filtered level while enabled
    always_comb begin
        evt_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            evt_c[i] = i_enable &
                       (( level_q[i] & ~level_prev_q[i] & i_edge_sel[2*i])   |
                        (~level_q[i] &  level_prev_q[i] & i_edge_sel[2*i+1]));
        end
    end

    // Timestamp, channel-0 capture/count and sticky flags; clear overrides events
    always_comb begin
        ts_d      = ts_q;
        ts_last_d = ts_last_q;
        cnt_d     = cnt_q;
        flag_d    = (flag_q & ~i_flag_clr) | evt_c;
        if (i_enable) begin
            ts_d = ts_q + TS_WIDTH'(1);
        end
        if (evt_c[0]) begin
            ts_last_d = ts_q;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
        if (i_clear) begin
            ts_d      = '0;
            ts_last_d = '0;
            cnt_d     = '0;
            flag_d    = '0;
        end
    end

    // State registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            meta_q       <= '0;
            sync_q       <= '0;
            filt_cnt_q   <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            pulse_q      <= '0;
            flag_q       <= '0;
            ts_q         <= '0;
            ts_last_q    <= '0;
            cnt_q        <= '0;
            irq_q        <= 1'b0;
        end else begin
            meta_q       <= i_di;
            sync_q       <= meta_q;
            filt_cnt_q   <= filt_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= evt_c;
            flag_q       <= flag_d;
            ts_q         <= ts_d;
            ts_last_q    <= ts_last_d;
            cnt_q        <= cnt_d;
            irq_q        <= |(flag_q & i_irq_mask);
        end
    end

    assign o_di_level  = level_q;
    assign o_evt_pulse = pulse_q;
    assign o_evt_flag  = flag_q;
    assign o_ts_free   = ts_q;
    assign o_ts_last   = ts_last_q;
    assign o_evt_cnt   = cnt_q;
    assign o_irq       = irq_q;

endmodule
